jk_bank_arbiter: RTL and testbench

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

---
 rtl/jk_bank_arbiter.sv | 125 ++++++++++++
 tb/tb_jk_bank_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Four-requester arbiter sharing a bank of WIDTH JK flip-flops, one masked op per 2 cycles.
// Define JKARB_FIXED_PRIO_EN for fixed priority (requester 0 highest); default is round-robin.
module jk_bank_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [7:0]         op,
    input  logic [4*WIDTH-1:0] mask,
    output logic [3:0]         gnt,
    output logic [WIDTH-1:0]   q,
    output logic               busy
);

    // state   | meaning
    // S_IDLE  | waiting for a request; winner latched on the edge that leaves
    // S_APPLY | gnt pulse for the winner; bank updated on the edge that leaves

    typedef enum logic {S_IDLE, S_APPLY} state_t;

    state_t             r_state;
    logic [1:0]         r_ptr;
    logic [1:0]         r_win;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_q;
    logic [3:0]         r_gnt;
    logic               r_busy;

    logic [1:0]         w_winner;
    logic [1:0]         w_op_sel;
    logic [WIDTH-1:0]   w_mask_sel;
    logic [WIDTH-1:0]   w_jk;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [1:0]         w_ptr_nxt;

`ifdef JKARB_FIXED_PRIO_EN
    always_comb begin
        w_winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) w_winner = 2'(i);
        end
    end

    assign w_ptr_nxt = 2'd0;
`else
    logic [1:0] w_idx;
    logic       w_found;

    // Search upward from the pointer, wrapping modulo 4.
    always_comb begin
        w_winner = r_ptr;
        w_found  = 1'b0;
        w_idx    = r_ptr;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = r_win + 2'd1;
`endif

    always_comb begin
        w_op_sel   = 2'b00;
        w_mask_sel = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_winner == 2'(i)) begin
                w_op_sel   = op[2*i +: 2];
                w_mask_sel = mask[i*WIDTH +: WIDTH];
            end
        end
    end

    // JK next state: Q+ = J&~Q | ~K&Q, with J = op[1], K = op[0].
    assign w_jk    = ({WIDTH{r_op[1]}} & ~r_q) | ({WIDTH{~r_op[0]}} & r_q);
    assign w_q_nxt = (r_mask & w_jk) | (~r_mask & r_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_win   <= 2'd0;
            r_op    <= 2'b00;
            r_mask  <= '0;
            r_q     <= '0;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_state <= S_APPLY;
                        r_win   <= w_winner;
                        r_op    <= w_op_sel;
                        r_mask  <= w_mask_sel;
                        r_gnt   <= 4'b0001 << w_winner;
                        r_busy  <= 1'b1;
                    end
                end
                S_APPLY: begin
                    r_state <= S_IDLE;
                    r_q     <= w_q_nxt;
                    r_ptr   <= w_ptr_nxt;
                    r_gnt   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign q    = r_q;
    assign busy = r_busy;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter (default round-robin build, WIDTH = 8).
module tb_jk_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] mask;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  op;
        logic [31:0] mask;
        logic [3:0]  gnt;
        logic [7:0]  q;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    jk_bank_arbiter #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .op   (op),
        .mask (mask),
        .gnt  (gnt),
        .q    (q),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // gnt must be one-hot and only during APPLY (busy high).
    always @(negedge clk) begin
        if (rst && gnt != 4'b0000)
            chk("gnt_onehot_in_apply", {31'b0, busy && $onehot(gnt)}, 32'd1);
    end

    task automatic run_op(input string name, input logic [3:0] r, input logic [7:0] o,
                          input logic [31:0] m, input logic [3:0] eg, input logic [7:0] eq,
                          input bit late);
        exp_t e;
        int   k;
        @(negedge clk);
        req  = r;
        op   = o;
        mask = m;
        e.gnt = eg;
        e.q   = eq;
        sb.push_back(e);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (gnt == 4'b0000 && k < 4);
        chk({name, "_latency"}, k, 32'd1);
        e = sb.pop_front();
        chk({name, "_gnt"}, {28'b0, gnt}, {28'b0, e.gnt});
        chk({name, "_busy_hi"}, {31'b0, busy}, 32'd1);
        req = 4'b0000;
        if (late) begin
            op   = 8'hFF;
            mask = 32'h0;
        end
        @(negedge clk);
        chk({name, "_q"}, {24'b0, q}, {24'b0, e.q});
        chk({name, "_busy_lo"}, {31'b0, busy}, 32'd0);
        chk({name, "_gnt_lo"}, {28'b0, gnt}, 32'd0);
    endtask

    initial begin
        exp_t       e;
        logic [7:0] last_q;

        vecs[0] = '{4'b0001, 8'h02, 32'h0000000F, 4'b0001, 8'h0F};
        vecs[1] = '{4'b0010, 8'h0C, 32'h00003C00, 4'b0010, 8'h33};
        vecs[2] = '{4'b0100, 8'h10, 32'h00F00000, 4'b0100, 8'h03};
        vecs[3] = '{4'b1000, 8'h80, 32'h81000000, 4'b1000, 8'h83};
        vecs[4] = '{4'b0011, 8'h0C, 32'h0000FFFF, 4'b0001, 8'h83};
        vecs[5] = '{4'b1001, 8'hC2, 32'h0F0000FF, 4'b1000, 8'h8C};
        vecs[6] = '{4'b0110, 8'h38, 32'h00FF7000, 4'b0010, 8'hFC};
        vecs[7] = '{4'b1100, 8'h90, 32'hFF0C0000, 4'b0100, 8'hF0};
        vecs[8] = '{4'b0001, 8'h03, 32'h00000000, 4'b0001, 8'hF0};
        vecs[9] = '{4'b1111, 8'hB6, 32'hFFFF30FF, 4'b0010, 8'hC0};

        rst  = 1'b0;
        req  = 4'b0000;
        op   = 8'h00;
        mask = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_gnt", {28'b0, gnt}, 32'd0);
        chk("reset_q", {24'b0, q}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].req, vecs[i].op, vecs[i].mask,
                   vecs[i].gnt, vecs[i].q, 1'b0);

        // Round-robin sweep from a freshly reset pointer with all requests held.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        req  = 4'b1111;
        op   = 8'hFF;
        mask = 32'h08040201;
        e = '{4'b0001, 8'h01}; sb.push_back(e);
        e = '{4'b0010, 8'h03}; sb.push_back(e);
        e = '{4'b0100, 8'h07}; sb.push_back(e);
        e = '{4'b1000, 8'h0F}; sb.push_back(e);
        e = '{4'b0001, 8'h0E}; sb.push_back(e);
        last_q = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k % 2 == 1) begin
                e = sb.pop_front();
                chk($sformatf("sweep%0d_gnt", k), {28'b0, gnt}, {28'b0, e.gnt});
                chk($sformatf("sweep%0d_busy", k), {31'b0, busy}, 32'd1);
                last_q = e.q;
                if (k == 9) req = 4'b0000;
            end else begin
                chk($sformatf("sweep%0d_gap", k), {28'b0, gnt}, 32'd0);
                chk($sformatf("sweep%0d_q", k), {24'b0, q}, {24'b0, last_q});
            end
        end

        // Reset in the middle of an APPLY cycle.
        @(negedge clk);
        req  = 4'b0001;
        op   = 8'h02;
        mask = 32'h000000FF;
        @(negedge clk);
        chk("midrst_gnt_seen", {28'b0, gnt}, 32'd1);
        req = 4'b0000;
        #2 rst = 1'b0;
        #1;
        chk("midrst_gnt", {28'b0, gnt}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_q", {24'b0, q}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_idle_q", {24'b0, q}, 32'd0);
        chk("midrst_idle_busy", {31'b0, busy}, 32'd0);
        chk("midrst_idle_gnt", {28'b0, gnt}, 32'd0);

        run_op("post_rst", 4'b1111, 8'hAA, 32'hF0F0F00F, 4'b0001, 8'h0F, 1'b0);
        run_op("late_hold", 4'b0100, 8'h00, 32'h00FF0000, 4'b0100, 8'h0F, 1'b1);
        run_op("late_set", 4'b0100, 8'h20, 32'h00F00000, 4'b0100, 8'hFF, 1'b1);

        // Request pulse that disappears before any edge samples it.
        @(negedge clk);
        #1 req = 4'b1000;
        #2 req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("drop%0d_gnt", k), {28'b0, gnt}, 32'd0);
            chk($sformatf("drop%0d_q", k), {24'b0, q}, 32'hFF);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
